control_unit: RTL and testbench



---
 rtl/control_unit_pkg.sv | 101 ++++++++++
 rtl/control_unit_if.sv | 30 +++
 rtl/control_unit_sequence_counter.sv | 34 +++
 rtl/control_unit.sv | 163 ++++++++++++++++
 tb/tb_control_unit.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/control_unit_pkg.sv
// Shared encodings for the control unit and the datapath it drives:
// opcodes, register maps, select codes and the packed control word.
package control_unit_pkg;

    localparam logic [5:0] OP_BRA = 6'h00;
    localparam logic [5:0] OP_BNE = 6'h01;
    localparam logic [5:0] OP_LDI = 6'h02;
    localparam logic [5:0] OP_LDM = 6'h03;
    localparam logic [5:0] OP_ADD = 6'h04;
    localparam logic [5:0] OP_SUB = 6'h05;
    localparam logic [5:0] OP_AND = 6'h06;
    localparam logic [5:0] OP_ORR = 6'h07;
    localparam logic [5:0] OP_ST  = 6'h08;

    localparam logic [2:0] RF_FUN_LOAD   = 3'b010;
    localparam logic [2:0] ARF_FUN_INC   = 3'b001;
    localparam logic [2:0] ARF_FUN_LOAD  = 3'b010;
    localparam logic [2:0] ARF_FUN_CLEAR = 3'b011;

    localparam logic [4:0] ALU_FUN_PASSA = 5'b10000;
    localparam logic [4:0] ALU_FUN_ADD   = 5'b10100;
    localparam logic [4:0] ALU_FUN_SUB   = 5'b10101;
    localparam logic [4:0] ALU_FUN_AND   = 5'b10111;
    localparam logic [4:0] ALU_FUN_ORR   = 5'b11000;

    // Register file write masks, one bit per register R1..R4.
    localparam logic [3:0] RF_REGSEL_NONE = 4'b0000;
    localparam logic [3:0] RF_REGSEL_R1   = 4'b1000;
    localparam logic [3:0] RF_REGSEL_R2   = 4'b0100;
    localparam logic [3:0] RF_REGSEL_R3   = 4'b0010;
    localparam logic [3:0] RF_REGSEL_R4   = 4'b0001;
    localparam logic [3:0] RF_SCRSEL_NONE = 4'b0000;

    localparam logic [1:0] ARF_PC = 2'b00;
    localparam logic [1:0] ARF_SP = 2'b01;
    localparam logic [1:0] ARF_AR = 2'b10;

    localparam logic [2:0] ARF_REGSEL_NONE = 3'b000;
    localparam logic [2:0] ARF_REGSEL_PC   = 3'b100;
    localparam logic [2:0] ARF_REGSEL_AR   = 3'b010;
    localparam logic [2:0] ARF_REGSEL_SP   = 3'b001;

    localparam logic [1:0] MUXA_ALU = 2'b00;
    localparam logic [1:0] MUXA_MEM = 2'b10;
    localparam logic [1:0] MUXA_IMM = 2'b11;
    localparam logic [1:0] MUXB_IMM = 2'b11;

    typedef enum logic [1:0] {SC_T0, SC_T1, SC_T2, SC_T3} sc_t;

    typedef struct packed {
        logic [2:0] rf_outa;
        logic [2:0] rf_outb;
        logic [2:0] rf_fun;
        logic [3:0] rf_reg;
        logic [3:0] rf_scr;
        logic [4:0] alu_fun;
        logic       alu_wf;
        logic [1:0] arf_outc;
        logic [1:0] arf_outd;
        logic [2:0] arf_fun;
        logic [2:0] arf_reg;
        logic       ir_lh;
        logic       ir_write;
        logic       mem_wr;
        logic       mem_cs;
        logic [1:0] mux_a;
        logic [1:0] mux_b;
        logic       mux_c;
    } ctrl_t;

    function automatic ctrl_t ctrl_idle();
        ctrl_t c;
        c        = '0;
        c.rf_reg = RF_REGSEL_NONE;
        c.rf_scr = RF_SCRSEL_NONE;
        c.arf_reg = ARF_REGSEL_NONE;
        c.mem_cs = 1'b1;
        return c;
    endfunction

    // Register codes 0..3 name R1..R4; anything else writes nothing.
    function automatic logic [3:0] rf_regsel(input logic [2:0] code);
        case (code)
            3'd0:    return RF_REGSEL_R1;
            3'd1:    return RF_REGSEL_R2;
            3'd2:    return RF_REGSEL_R3;
            3'd3:    return RF_REGSEL_R4;
            default: return RF_REGSEL_NONE;
        endcase
    endfunction

    function automatic logic [4:0] alu_fun_of(input logic [1:0] op_lo);
        case (op_lo)
            2'b00:   return ALU_FUN_ADD;
            2'b01:   return ALU_FUN_SUB;
            2'b10:   return ALU_FUN_AND;
            default: return ALU_FUN_ORR;
        endcase
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control/status bundle between the sequencer and the datapath wrapper.
interface control_unit_if;
    logic [15:0] IROut;
    logic [3:0]  ALU_Flags;
    logic [2:0]  RF_OutASel, RF_OutBSel, RF_FunSel;
    logic [3:0]  RF_RegSel, RF_ScrSel;
    logic [4:0]  ALU_FunSel;
    logic        ALU_WF;
    logic [1:0]  ARF_OutCSel, ARF_OutDSel;
    logic [2:0]  ARF_FunSel, ARF_RegSel;
    logic        IR_LH, IR_Write, Mem_WR, Mem_CS;
    logic [1:0]  MuxASel, MuxBSel;
    logic        MuxCSel;

    modport master (
        input  IROut, ALU_Flags,
        output RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
               ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
               ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS, MuxASel, MuxBSel,
               MuxCSel
    );

    modport slave (
        output IROut, ALU_Flags,
        input  RF_OutASel, RF_OutBSel, RF_FunSel, RF_RegSel, RF_ScrSel,
               ALU_FunSel, ALU_WF, ARF_OutCSel, ARF_OutDSel, ARF_FunSel,
               ARF_RegSel, IR_LH, IR_Write, Mem_WR, Mem_CS, MuxASel, MuxBSel,
               MuxCSel
    );
endinterface

// File: rtl/control_unit_sequence_counter.sv
// Timing-step counter. Clear wins over hold, hold wins over increment.
module sequence_counter #(
    parameter int unsigned SC_WIDTH = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    input  logic                inc,
    input  logic                hold,
    output logic [SC_WIDTH-1:0] count
);

    logic [SC_WIDTH-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (hold)
            count_d = count_q;
        else if (inc)
            count_d = count_q + SC_WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/control_unit.sv
// Hardwired fetch/decode/execute sequencer. Only T and the halt flag are
// stored; every control output is a decode of (T, IROut, Z, halt).
module control_unit
    import control_unit_pkg::*;
#(
    parameter int unsigned SC_WIDTH   = 3,
    parameter logic [5:0]  HLT_OPCODE = 6'h3F
) (
    input  logic                Clock,
    input  logic                Reset,
    control_unit_if.master      bus,
    output logic [SC_WIDTH-1:0] T,
    output logic                Halted
);

    logic [SC_WIDTH-1:0] t;
    logic                halt_d, halt_q;
    logic                t_illegal, seq_last;
    sc_t                 t_st;
    ctrl_t               c;

    logic [5:0] opcode;
    logic [1:0] rsel;
    logic       s_bit, z;
    logic [2:0] dst, src1, src2;
    logic       unused_flags;

    assign opcode       = bus.IROut[15:10];
    assign rsel         = bus.IROut[9:8];
    assign s_bit        = bus.IROut[9];
    assign dst          = bus.IROut[8:6];
    assign src1         = bus.IROut[5:3];
    assign src2         = bus.IROut[2:0];
    assign z            = bus.ALU_Flags[3];
    assign unused_flags = ^bus.ALU_Flags[2:0];

    sequence_counter #(.SC_WIDTH(SC_WIDTH)) u_sc (
        .clk   (Clock),
        .rst   (Reset),
        .clr   (seq_last),
        .inc   (1'b1),
        .hold  (halt_q),
        .count (t)
    );

    // Any count past T3 is unreachable in normal flow; it is cleared next edge.
    always_comb begin
        t_illegal = |(t >> 2);
        t_st      = sc_t'(t[1:0]);
        seq_last  = t_illegal || (t_st == SC_T3) ||
                    ((t_st == SC_T2) && (opcode != OP_ST));
    end

    always_comb begin
        halt_d = halt_q;
        if (!halt_q && !t_illegal && (t_st == SC_T2) && (opcode == HLT_OPCODE))
            halt_d = 1'b1;
    end

    always_ff @(posedge Clock) begin
        if (Reset)
            halt_q <= 1'b0;
        else
            halt_q <= halt_d;
    end

    always_comb begin
        c = ctrl_idle();
        if (Reset) begin
            c.arf_fun = ARF_FUN_CLEAR;
            c.arf_reg = ARF_REGSEL_PC;
        end else if (!halt_q && !t_illegal) begin
            case (t_st)
                SC_T0, SC_T1: begin
                    c.arf_outd = ARF_PC;
                    c.mem_cs   = 1'b0;
                    c.ir_write = 1'b1;
                    c.ir_lh    = (t_st == SC_T1);
                    c.arf_fun  = ARF_FUN_INC;
                    c.arf_reg  = ARF_REGSEL_PC;
                end
                SC_T2: begin
                    case (opcode)
                        OP_BRA, OP_BNE: begin
                            if (opcode == OP_BRA || !z) begin
                                c.mux_b   = MUXB_IMM;
                                c.arf_fun = ARF_FUN_LOAD;
                                c.arf_reg = ARF_REGSEL_PC;
                            end
                        end
                        OP_LDI: begin
                            c.mux_a  = MUXA_IMM;
                            c.rf_fun = RF_FUN_LOAD;
                            c.rf_reg = rf_regsel({1'b0, rsel});
                        end
                        OP_LDM: begin
                            c.arf_outd = ARF_AR;
                            c.mem_cs   = 1'b0;
                            c.mux_a    = MUXA_MEM;
                            c.rf_fun   = RF_FUN_LOAD;
                            c.rf_reg   = rf_regsel({1'b0, rsel});
                        end
                        OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
                            c.rf_outa = src1;
                            c.rf_outb = src2;
                            c.alu_fun = alu_fun_of(opcode[1:0]);
                            c.alu_wf  = s_bit;
                            c.mux_a   = MUXA_ALU;
                            c.rf_fun  = RF_FUN_LOAD;
                            c.rf_reg  = rf_regsel(dst);
                        end
                        OP_ST: begin
                            // Low byte first; AR steps so T3 lands on the next byte.
                            c.rf_outa  = {1'b0, rsel};
                            c.alu_fun  = ALU_FUN_PASSA;
                            c.arf_outd = ARF_AR;
                            c.mem_cs   = 1'b0;
                            c.mem_wr   = 1'b1;
                            c.mux_c    = 1'b0;
                            c.arf_fun  = ARF_FUN_INC;
                            c.arf_reg  = ARF_REGSEL_AR;
                        end
                        default: ;
                    endcase
                end
                SC_T3: begin
                    if (opcode == OP_ST) begin
                        c.rf_outa  = {1'b0, rsel};
                        c.alu_fun  = ALU_FUN_PASSA;
                        c.arf_outd = ARF_AR;
                        c.mem_cs   = 1'b0;
                        c.mem_wr   = 1'b1;
                        c.mux_c    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.RF_OutASel  = c.rf_outa;
    assign bus.RF_OutBSel  = c.rf_outb;
    assign bus.RF_FunSel   = c.rf_fun;
    assign bus.RF_RegSel   = c.rf_reg;
    assign bus.RF_ScrSel   = c.rf_scr;
    assign bus.ALU_FunSel  = c.alu_fun;
    assign bus.ALU_WF      = c.alu_wf;
    assign bus.ARF_OutCSel = c.arf_outc;
    assign bus.ARF_OutDSel = c.arf_outd;
    assign bus.ARF_FunSel  = c.arf_fun;
    assign bus.ARF_RegSel  = c.arf_reg;
    assign bus.IR_LH       = c.ir_lh;
    assign bus.IR_Write    = c.ir_write;
    assign bus.Mem_WR      = c.mem_wr;
    assign bus.Mem_CS      = c.mem_cs;
    assign bus.MuxASel     = c.mux_a;
    assign bus.MuxBSel     = c.mux_b;
    assign bus.MuxCSel     = c.mux_c;

    assign T      = t;
    assign Halted = halt_q;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed instructions, then random ones, each
// checked cycle by cycle against an instruction-level expected sequence.
module tb_control_unit;
    import control_unit_pkg::*;

    localparam logic [5:0] HLT = 6'h3F;

    logic       Clock = 1'b0;
    logic       Reset;
    logic [2:0] T;
    logic       Halted;

    control_unit_if bus();

    control_unit #(.SC_WIDTH(3), .HLT_OPCODE(HLT)) dut (
        .Clock  (Clock),
        .Reset  (Reset),
        .bus    (bus.master),
        .T      (T),
        .Halted (Halted)
    );

    always #5 Clock = ~Clock;

    int    total = 0;
    int    bad   = 0;
    ctrl_t expq[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic ctrl_t observed();
        ctrl_t o;
        o.rf_outa  = bus.RF_OutASel;  o.rf_outb  = bus.RF_OutBSel;
        o.rf_fun   = bus.RF_FunSel;   o.rf_reg   = bus.RF_RegSel;
        o.rf_scr   = bus.RF_ScrSel;   o.alu_fun  = bus.ALU_FunSel;
        o.alu_wf   = bus.ALU_WF;      o.arf_outc = bus.ARF_OutCSel;
        o.arf_outd = bus.ARF_OutDSel; o.arf_fun  = bus.ARF_FunSel;
        o.arf_reg  = bus.ARF_RegSel;  o.ir_lh    = bus.IR_LH;
        o.ir_write = bus.IR_Write;    o.mem_wr   = bus.Mem_WR;
        o.mem_cs   = bus.Mem_CS;      o.mux_a    = bus.MuxASel;
        o.mux_b    = bus.MuxBSel;     o.mux_c    = bus.MuxCSel;
        return o;
    endfunction

    function automatic ctrl_t idle_w();
        ctrl_t w = '0;
        w.rf_reg = RF_REGSEL_NONE;  w.rf_scr = RF_SCRSEL_NONE;
        w.arf_reg = ARF_REGSEL_NONE; w.mem_cs = 1'b1;
        return w;
    endfunction

    function automatic ctrl_t reset_w();
        ctrl_t w = idle_w();
        w.arf_fun = ARF_FUN_CLEAR; w.arf_reg = ARF_REGSEL_PC;
        return w;
    endfunction

    function automatic ctrl_t fetch_w(input bit hi);
        ctrl_t w = idle_w();
        w.arf_outd = ARF_PC; w.mem_cs = 1'b0; w.ir_write = 1'b1; w.ir_lh = hi;
        w.arf_fun = ARF_FUN_INC; w.arf_reg = ARF_REGSEL_PC;
        return w;
    endfunction

    function automatic logic [3:0] rmask(input int code);
        logic [3:0] tab [4] = '{RF_REGSEL_R1, RF_REGSEL_R2, RF_REGSEL_R3, RF_REGSEL_R4};
        return (code < 4) ? tab[code] : RF_REGSEL_NONE;
    endfunction

    // Expected per-cycle control words for one instruction, from its effect.
    task automatic build_exp(input logic [15:0] ir, input logic z, output bit halts);
        logic [4:0] alu_tab [4] = '{ALU_FUN_ADD, ALU_FUN_SUB, ALU_FUN_AND, ALU_FUN_ORR};
        int    op = int'(ir[15:10]);
        int    rs = int'(ir[9:8]);
        ctrl_t w  = idle_w();
        ctrl_t w2;
        halts = 0;
        expq.delete();
        expq.push_back(fetch_w(0));
        expq.push_back(fetch_w(1));
        if (op == int'(OP_BRA) || (op == int'(OP_BNE) && !z)) begin
            w.mux_b = MUXB_IMM; w.arf_fun = ARF_FUN_LOAD; w.arf_reg = ARF_REGSEL_PC;
        end else if (op == int'(OP_LDI)) begin
            w.mux_a = MUXA_IMM; w.rf_fun = RF_FUN_LOAD; w.rf_reg = rmask(rs);
        end else if (op == int'(OP_LDM)) begin
            w.arf_outd = ARF_AR; w.mem_cs = 1'b0; w.mux_a = MUXA_MEM;
            w.rf_fun = RF_FUN_LOAD; w.rf_reg = rmask(rs);
        end else if (op >= 4 && op <= 7) begin
            w.rf_outa = ir[5:3]; w.rf_outb = ir[2:0]; w.alu_fun = alu_tab[op-4];
            w.alu_wf = ir[9]; w.mux_a = MUXA_ALU; w.rf_fun = RF_FUN_LOAD;
            w.rf_reg = rmask(int'(ir[8:6]));
        end else if (op == int'(OP_ST)) begin
            w.rf_outa = 3'(rs); w.alu_fun = ALU_FUN_PASSA; w.arf_outd = ARF_AR;
            w.mem_cs = 1'b0; w.mem_wr = 1'b1;
            w2 = w;
            w.arf_fun = ARF_FUN_INC; w.arf_reg = ARF_REGSEL_AR;
            w2.mux_c = 1'b1;
            expq.push_back(w);
            w = w2;
        end else if (op == int'(HLT)) begin
            halts = 1;
        end
        expq.push_back(w);
    endtask

    // Runs one instruction; abort_at >= 0 raises Reset in that cycle instead.
    task automatic run_instr(input logic [15:0] ir, input logic z, input int abort_at,
                             output bit halted_now);
        bit halts;
        build_exp(ir, z, halts);
        halted_now = 0;
        for (int k = 0; k < expq.size(); k++) begin
            @(negedge Clock);
            Reset = (k == abort_at);
            bus.IROut     = (k < 2) ? 16'($urandom) : ir;
            bus.ALU_Flags = (k < 2) ? 4'($urandom) : {z, 3'($urandom)};
            #1;
            chk($sformatf("T k%0d ir%h", k, ir), 64'(T), 64'(k));
            if (k == abort_at) begin
                chk($sformatf("abort ctl k%0d ir%h", k, ir), 64'(observed()), 64'(reset_w()));
                return;
            end
            chk($sformatf("ctl k%0d ir%h z%0d", k, ir, z), 64'(observed()), 64'(expq[k]));
            chk("halted_run", 64'(Halted), 64'(0));
        end
        if (halts) begin
            halted_now = 1;
            for (int k = 0; k < 20; k++) begin
                @(negedge Clock);
                bus.IROut = 16'($urandom); bus.ALU_Flags = 4'($urandom);
                #1;
                chk("halt ctl", 64'(observed()), 64'(idle_w()));
                chk("halt T", 64'(T), 64'(0));
                chk("halt flag", 64'(Halted), 64'(1));
            end
        end
    endtask

    task automatic do_reset();
        @(negedge Clock);
        Reset = 1'b1;
        bus.IROut = 16'($urandom);
        #1;
        chk("reset ctl", 64'(observed()), 64'(reset_w()));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        bit h;
        logic [5:0] op;
        Reset = 1'b0; bus.IROut = '0; bus.ALU_Flags = '0;
        do_reset();
        run_instr(16'h095A, 1'b0, -1, h);   // LDI R2,0x5A
        run_instr(16'h120A, 1'b0, -1, h);   // ADD S=1 R1<-R2+R3
        run_instr(16'h0420, 1'b0, -1, h);   // BNE taken
        run_instr(16'h0420, 1'b1, -1, h);   // BNE not taken
        run_instr(16'h2000, 1'b0, -1, h);   // ST R1
        run_instr(16'h2000, 1'b0, 3, h);    // ST aborted in T3
        run_instr(16'h0800, 1'b0, -1, h);   // LDI right after abort
        run_instr(16'hFC00, 1'b0, -1, h);   // HLT
        do_reset();
        for (int i = 0; i < 300; i++) begin
            int sel = $urandom_range(0, 11);
            int ab  = ($urandom_range(0, 19) == 0) ? $urandom_range(0, 2) : -1;
            if (sel <= 8)      op = 6'(sel);
            else if (sel == 9) op = HLT;
            else               op = 6'($urandom_range(9, 62));
            run_instr({op, 10'($urandom)}, 1'($urandom), ab, h);
            if (h) do_reset();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
